// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and its datapath/memory (slave).
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       addr_sel;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ALUOp;
    logic       aluout_write;
    logic       reg_write;
    logic       wb_sel;
    logic       retire;
    logic [1:0] fault;
    logic [2:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, addr_sel, ir_write, mdr_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ALUOp, aluout_write, reg_write, wb_sel, retire,
               fault, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, addr_sel, ir_write, mdr_write, pc_write, pc_src,
               alu_src_a, alu_src_b, ALUOp, aluout_write, reg_write, wb_sel, retire,
               fault, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 R/LW/SW/BEQ subset with a shared
// memory port, req/ready handshake and a memory-stall watchdog that traps into a sticky fault.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_LW   = 3'd2,
        C_SW   = 3'd3,
        C_BEQ  = 3'd4
    } class_t;

    state_t        state_q, state_d;
    class_t        class_q, class_d;
    logic [1:0]    fault_q, fault_d;
    logic [CW-1:0] wait_q,  wait_d;
    logic          timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            class_q <= C_NONE;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    // Stall watchdog fires only on a non-ready cycle at the last allowed count; ready wins.
    assign timeout = (MEM_TIMEOUT != 0) && !bus.mem_ready && (wait_q == CNT_LAST);

    assign bus.fault = fault_q;
    assign bus.state = state_q;

    always_comb begin
        state_d          = state_q;
        class_d          = class_q;
        fault_d          = fault_q;
        wait_d           = wait_q;
        bus.mem_req      = 1'b0;
        bus.mem_write    = 1'b0;
        bus.addr_sel     = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mdr_write    = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = 1'b0;
        bus.alu_src_a    = 2'd0;
        bus.alu_src_b    = 2'd0;
        bus.ALUOp        = 2'b00;
        bus.aluout_write = 1'b0;
        bus.reg_write    = 1'b0;
        bus.wb_sel       = 1'b0;
        bus.retire       = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                wait_d  = '0;
            end

            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'd1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    wait_d       = '0;
                    state_d      = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                    if (fault_q == FAULT_NONE) fault_d = FAULT_TIMEOUT;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + CW'(1);
                end
            end

            DECODE: begin
                bus.alu_src_a    = 2'd2;
                bus.alu_src_b    = 2'd2;
                bus.aluout_write = 1'b1;
                state_d          = EXEC;
                unique case (bus.opcode)
                    OP_R:    class_d = C_R;
                    OP_LW:   class_d = C_LW;
                    OP_SW:   class_d = C_SW;
                    OP_BEQ:  class_d = C_BEQ;
                    default: begin
                        class_d = C_NONE;
                        state_d = TRAP;
                        if (fault_q == FAULT_NONE) fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end

            EXEC: begin
                bus.alu_src_a = 2'd1;
                wait_d        = '0;
                unique case (class_q)
                    C_R: begin
                        bus.ALUOp        = 2'b10;
                        bus.aluout_write = 1'b1;
                        state_d          = WB;
                    end
                    C_LW, C_SW: begin
                        bus.alu_src_b    = 2'd2;
                        bus.aluout_write = 1'b1;
                        state_d          = MEM;
                    end
                    C_BEQ: begin
                        bus.ALUOp    = 2'b01;
                        bus.pc_write = bus.zero;
                        bus.pc_src   = 1'b1;
                        bus.retire   = 1'b1;
                        state_d      = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end

            MEM: begin
                bus.mem_req   = 1'b1;
                bus.addr_sel  = 1'b1;
                bus.mem_write = (class_q == C_SW);
                if (bus.mem_ready) begin
                    wait_d = '0;
                    if (class_q == C_LW) begin
                        bus.mdr_write = 1'b1;
                        state_d       = WB;
                    end else begin
                        bus.retire = 1'b1;
                        state_d    = FETCH;
                    end
                end else if (timeout) begin
                    state_d = TRAP;
                    if (fault_q == FAULT_NONE) fault_d = FAULT_TIMEOUT;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + CW'(1);
                end
            end

            WB: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = (class_q == C_LW);
                bus.retire    = 1'b1;
                wait_d        = '0;
                state_d       = FETCH;
            end

            TRAP: state_d = TRAP;

            default: state_d = BOOT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: per-instruction expected cycle tables built from the instruction class
// and the chosen memory stall lengths, compared against every DUT output on every cycle.
module tb_multicycle_controller;

    localparam int unsigned TO = 16;
    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ILL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_write, addr_sel, ir_write, mdr_write, pc_write, pc_src;
        logic [1:0] a, b, op;
        logic       aluout_write, reg_write, wb_sel, retire;
        logic [1:0] fault;
        logic [2:0] state;
    } obs_t;

    int n_err = 0, n_chk = 0, cyc_no = 0, ret_seen = 0, ret_cyc = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] op_of(input int cls);
        logic [6:0] t [4] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011};
        return t[cls];
    endfunction

    function automatic obs_t sample();
        return obs_t'({bus.mem_req, bus.mem_write, bus.addr_sel, bus.ir_write, bus.mdr_write,
                       bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.ALUOp,
                       bus.aluout_write, bus.reg_write, bus.wb_sel, bus.retire, bus.fault, bus.state});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_no, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs mid-cycle, advance past the next edge.
    task automatic cyc(input logic rdy, input logic [6:0] op, input logic z, input obs_t e,
                       input string name);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        bus.zero      = z;
        @(negedge clk);
        check(name, 32'(sample()), 32'(e));
        if (bus.retire === 1'b1) begin
            ret_seen++;
            ret_cyc = cyc_no;
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(rb(), 7'($urandom), rb(), '0, "reset");
        cyc(rb(), 7'($urandom), rb(), '0, "reset");
        rst_n = 1'b1;
        cyc(rb(), 7'($urandom), rb(), '0, "boot");
    endtask

    task automatic trap(input logic [1:0] code);
        obs_t e;
        e       = '0;
        e.state = 3'd6;
        e.fault = code;
        for (int i = 0; i < 3; i++) cyc(rb(), 7'($urandom), rb(), e, "trap");
        check("trap_fault", 32'(bus.fault), 32'(code));
        do_reset();
    endtask

    // Runs one instruction; fw/mw are the non-ready cycles before mem_ready in FETCH/MEM.
    task automatic run_instr(input int cls, input int fw, input int mw, input logic zv,
                             input logic [6:0] illop);
        obs_t e;
        logic rdy;
        logic [6:0] op;
        int start, r0, lat;
        start = cyc_no;
        r0    = ret_seen;
        op    = (cls == C_ILL) ? illop : op_of(cls);

        for (int i = 0; i <= fw; i++) begin
            if (i == int'(TO)) begin
                trap(2'b10);
                return;
            end
            rdy        = (i == fw);
            e          = '0;
            e.state    = 3'd1;
            e.mem_req  = 1'b1;
            e.b        = 2'd1;
            e.ir_write = rdy;
            e.pc_write = rdy;
            cyc(rdy, 7'($urandom), rb(), e, "fetch");
        end

        e              = '0;
        e.state        = 3'd2;
        e.a            = 2'd2;
        e.b            = 2'd2;
        e.aluout_write = 1'b1;
        cyc(rb(), op, rb(), e, "decode");
        if (cls == C_ILL) begin
            trap(2'b01);
            return;
        end

        e       = '0;
        e.state = 3'd3;
        e.a     = 2'd1;
        case (cls)
            C_R:   begin e.op = 2'b10; e.aluout_write = 1'b1; end
            C_BEQ: begin e.op = 2'b01; e.pc_write = zv; e.pc_src = 1'b1; e.retire = 1'b1; end
            default: begin e.b = 2'd2; e.aluout_write = 1'b1; end
        endcase
        cyc(rb(), op, (cls == C_BEQ) ? zv : rb(), e, "exec");

        if (cls == C_LW || cls == C_SW) begin
            for (int i = 0; i <= mw; i++) begin
                if (i == int'(TO)) begin
                    trap(2'b10);
                    return;
                end
                rdy         = (i == mw);
                e           = '0;
                e.state     = 3'd4;
                e.mem_req   = 1'b1;
                e.addr_sel  = 1'b1;
                e.mem_write = (cls == C_SW);
                e.mdr_write = rdy && (cls == C_LW);
                e.retire    = rdy && (cls == C_SW);
                cyc(rdy, op, rb(), e, "mem");
            end
        end

        if (cls == C_R || cls == C_LW) begin
            e           = '0;
            e.state     = 3'd5;
            e.reg_write = 1'b1;
            e.wb_sel    = (cls == C_LW);
            e.retire    = 1'b1;
            cyc(rb(), op, rb(), e, "wb");
        end

        case (cls)
            C_R:     lat = 4 + fw;
            C_LW:    lat = 5 + fw + mw;
            C_SW:    lat = 4 + fw + mw;
            default: lat = 3 + fw;
        endcase
        check("retire_count", 32'(ret_seen - r0), 32'd1);
        check("latency", 32'(ret_cyc - start + 1), 32'(lat));
    endtask

    initial begin
        obs_t e;
        int cls, fw, mw, k;
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(C_R,   0, 0, 1'b0, 7'h00);
        run_instr(C_LW,  0, 3, 1'b0, 7'h00);
        run_instr(C_BEQ, 0, 0, 1'b1, 7'h00);
        run_instr(C_BEQ, 1, 0, 1'b0, 7'h00);
        run_instr(C_SW,  2, 1, 1'b0, 7'h00);
        run_instr(C_ILL, 0, 0, 1'b0, 7'b1111111);
        run_instr(C_R,  16, 0, 1'b0, 7'h00);
        run_instr(C_R,  15, 0, 1'b0, 7'h00);
        run_instr(C_SW,  0, 15, 1'b0, 7'h00);
        run_instr(C_LW,  0, 16, 1'b0, 7'h00);

        // Reset while a fetch is stalled must drop every output at once.
        e           = '0;
        e.state     = 3'd1;
        e.mem_req   = 1'b1;
        e.b         = 2'd1;
        cyc(1'b0, 7'h33, 1'b0, e, "fetch_pre_reset");
        do_reset();

        for (int n = 0; n < 80; n++) begin
            k   = int'($urandom_range(0, 19));
            cls = (k == 0) ? C_ILL : k % 4;
            k   = int'($urandom_range(0, 19));
            fw  = (k == 0) ? 16 : (k == 1) ? 15 : int'($urandom_range(0, 3));
            k   = int'($urandom_range(0, 19));
            mw  = (k == 0) ? 16 : (k == 1) ? 15 : int'($urandom_range(0, 3));
            run_instr(cls, fw, mw, rb(), (k < 10) ? 7'b1111111 : 7'b0010011);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
